// File: rtl/apuf_challenge_driver.sv
// Challenge sequencer for an arbiter PUF.
// For each challenge: select lines settle (LOAD), the arbiter is released
// (ARM), the race edge is launched and propagates (FIRE, SAMPLE), the arbiter
// output is captured, and the response is offered on a valid/ready port (OUT).
// Successive challenges come from a Fibonacci-style LFSR stepped on each
// accepted response.
//
// Handshake: resp_valid is high only in OUT, and resp_bit and challenge hold
// stable while it is high. A response transfers on a rising clk edge where
// resp_valid && resp_ready; resp_ready has no effect at any other time.
//
// Every output is a flop. Its next value is decoded from the next state, so
// the outputs line up with the registered state and cannot glitch.
module apuf_challenge_driver #(
    parameter int                CHAL_W = 64,
    parameter int                SETTLE = 4,
    parameter logic [CHAL_W-1:0] TAPS   = CHAL_W'(64'hD800_0000_0000_0000),
    parameter logic [CHAL_W-1:0] SEED   = CHAL_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_chal,
    input  logic [CHAL_W-1:0] chal_seed,
    output logic [CHAL_W-1:0] challenge,
    output logic              launch,
    output logic              arb_rst,
    input  logic              arb_q,
    output logic              resp_valid,
    output logic              resp_bit,
    input  logic              resp_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ARM    = 3'd2,
        FIRE   = 3'd3,
        SAMPLE = 3'd4,
        OUT    = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Value of the dwell counter on the final LOAD or FIRE cycle.
    localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [15:0]       remaining, remaining_n;
    logic [CHAL_W-1:0] challenge_n;
    logic [CHAL_W-1:0] lfsr_next;
    logic              launch_n;
    logic              arb_rst_n;
    logic              resp_valid_n;
    logic              busy_n;
    logic              done_n;

    // One LFSR step: shift left, feed back the parity of the tapped bits.
    assign lfsr_next = {challenge[CHAL_W-2:0], ^(challenge & TAPS)};

    // Next-state, run bookkeeping and registered-output decode.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        remaining_n = remaining;
        challenge_n = challenge;

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_chal != 16'd0) begin
                        remaining_n = num_chal;
                        challenge_n = (chal_seed == '0) ? SEED : chal_seed;
                        cnt_n       = 8'd0;
                        state_n     = LOAD;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            LOAD: begin
                if (cnt == LAST_CNT) begin
                    cnt_n   = 8'd0;
                    state_n = ARM;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ARM: begin
                cnt_n   = 8'd0;
                state_n = FIRE;
            end
            FIRE: begin
                if (cnt == LAST_CNT) begin
                    cnt_n   = 8'd0;
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            SAMPLE: begin
                state_n = OUT;
            end
            OUT: begin
                if (resp_ready) begin
                    remaining_n = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state_n = DONE;
                    end else begin
                        challenge_n = lfsr_next;
                        cnt_n       = 8'd0;
                        state_n     = LOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Race edge only in FIRE and SAMPLE. The arbiter is released one
        // cycle earlier (ARM), so launch and arb_rst are never both high.
        launch_n     = (state_n == FIRE) || (state_n == SAMPLE);
        arb_rst_n    = !((state_n == ARM) || (state_n == FIRE) || (state_n == SAMPLE));
        resp_valid_n = (state_n == OUT);
        busy_n       = (state_n != IDLE);
        done_n       = (state_n == DONE);
    end

    // State, run registers and output flops.
    // Reset abandons any run in progress; a pending response is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            remaining  <= 16'd0;
            challenge  <= '0;
            launch     <= 1'b0;
            arb_rst    <= 1'b1;
            resp_valid <= 1'b0;
            resp_bit   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            remaining  <= remaining_n;
            challenge  <= challenge_n;
            launch     <= launch_n;
            arb_rst    <= arb_rst_n;
            resp_valid <= resp_valid_n;
            busy       <= busy_n;
            done       <= done_n;
            // The arbiter is captured on the last cycle of the race window.
            if (state == SAMPLE) begin
                resp_bit <= arb_q;
            end
        end
    end

endmodule

// File: doc/apuf_challenge_driver.md
APUF_CHALLENGE_DRIVER -- requirements
Module: apuf_challenge_driver

Interface
REQ-001 The block SHALL have parameter CHAL_W, default 64, giving the challenge width in bits.
REQ-002 The block SHALL have parameter SETTLE, default 4, giving the cycles spent in each of LOAD and FIRE; legal range is 1..255.
REQ-003 The block SHALL have parameter TAPS, default 64'hD800_0000_0000_0000, giving the LFSR feedback mask.
REQ-004 The block SHALL have parameter SEED, default 1, giving the substitute challenge used when chal_seed is 0.
REQ-005 Reset is rst, synchronous, active-high; clock is clk.
REQ-006 The block SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  run request; sampled only in IDLE
- num_chal  in  16  challenges in the run; latched at start
- chal_seed  in  CHAL_W  first challenge; latched at start
- challenge  out  CHAL_W  drives the delay-chain select lines
- launch  out  1  race edge into both delay paths
- arb_rst  out  1  drives the arbiter flop reset; the arbiter holds 1 while arb_rst=1
- arb_q  in  1  arbiter flop output
- resp_valid  out  1  resp_bit is valid
- resp_bit  out  1  captured response
- resp_ready  in  1  consumer accepts the response
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run

Function
REQ-007 The FSM SHALL have exactly these states: IDLE, LOAD, ARM, FIRE, SAMPLE, OUT, DONE.
REQ-008 IDLE: launch=0 and arb_rst=1.
- start=1 with num_chal!=0 SHALL latch remaining=num_chal and challenge=chal_seed (SEED if chal_seed==0), then go to LOAD.
- start=1 with num_chal==0 SHALL go to DONE.
REQ-009 LOAD SHALL last SETTLE cycles with launch=0, arb_rst=1 and challenge stable, then go to ARM.
REQ-010 ARM SHALL last 1 cycle with launch=0 and arb_rst=0, then go to FIRE.
REQ-011 FIRE SHALL last SETTLE cycles with launch=1 and arb_rst=0, then go to SAMPLE.
REQ-012 SAMPLE SHALL last 1 cycle with launch=1 and arb_rst=0, and SHALL register resp_bit<=arb_q at its end; it then goes to OUT.
REQ-013 OUT: resp_valid=1, launch=0, arb_rst=1; resp_bit and challenge SHALL hold stable until the handshake (resp_valid && resp_ready).
REQ-014 On the OUT handshake:
- if remaining==1, go to DONE;
- otherwise remaining decrements, challenge advances one LFSR step, and the FSM goes to LOAD.
REQ-015 LFSR step SHALL be challenge <= {challenge[CHAL_W-2:0], ^(challenge & TAPS)}.
REQ-016 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-017 With resp_ready held at 1, per-challenge period SHALL be 2*SETTLE+3 cycles (11 at default).
REQ-018 start asserted in any state other than IDLE SHALL be ignored; num_chal and chal_seed changes after the latch SHALL have no effect.
REQ-019 resp_ready asserted outside OUT SHALL have no effect; resp_valid SHALL never be asserted outside OUT.
REQ-020 launch SHALL be 0 whenever arb_rst=1 in the same cycle, except at no point; launch and arb_rst are never both 1.
REQ-021 All outputs SHALL be registered and glitch-free.

Reset
REQ-022 rst=1 SHALL, at the next clk edge, force these values: state=IDLE, launch=0, arb_rst=1, resp_valid=0, resp_bit=0, busy=0, done=0, challenge=0, remaining=0.
REQ-023 Reset in any state, including mid-FIRE or OUT with a pending response, SHALL abort the run without a done pulse, and the pending response SHALL be discarded.

Verification
REQ-024 Single challenge:
- stimulus: start with num_chal=1, chal_seed=64'h1, arb_q=0, ready=1;
- response: resp_valid=1 with resp_bit=0 exactly 11 cycles after start is sampled, then done next cycle;
- launch is high for exactly 5 cycles.
REQ-025 LFSR sequence:
- stimulus: num_chal=3, chal_seed=64'h8000_0000_0000_0000;
- response: challenges 64'h8000_0000_0000_0000, 64'h1, 64'h2.
REQ-026 Backpressure:
- stimulus: ready=0 for 20 cycles in OUT, arb_q toggling;
- response: resp_bit, challenge and arb_rst=1 are held stable; the response is accepted on the first ready=1 cycle.
REQ-027 Zero and ignored requests:
- num_chal=0 -> done pulse 1 cycle after start, and launch never rises;
- start pulses during busy -> ignored, and the response count equals the original num_chal.
REQ-028 Mid-run reset:
- stimulus: rst asserted in FIRE of challenge 2 of 4;
- response: launch=0, arb_rst=1 and busy=0 on the next cycle, and no done pulse.
REQ-029 Zero seed:
- stimulus: chal_seed=0, SEED=1;
- response: the first challenge equals 64'h1.
